// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one async SRAM between ports A and B; define SRAM_ARB_RR_EN for round-robin ties, otherwise A wins ties
module sram_arbiter #(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 16,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              A_Req,
    input  logic              A_WE,
    input  logic [ADDR_W-1:0] A_Addr,
    input  logic [DATA_W-1:0] A_WData,
    output logic [DATA_W-1:0] A_RData,
    output logic              A_Ack,
    input  logic              B_Req,
    input  logic              B_WE,
    input  logic [ADDR_W-1:0] B_Addr,
    input  logic [DATA_W-1:0] B_WData,
    output logic [DATA_W-1:0] B_RData,
    output logic              B_Ack,
    output logic              Busy,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_UB_N,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ
);
    localparam int CW = ACCESS_CYCLES > 1 ? $clog2(ACCESS_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    state_t            state;
    logic [CW-1:0]     cnt;
    logic              op_we;
    logic              op_b;
    logic              dq_oe;
    logic [DATA_W-1:0] wdata_q;
    logic              grant_b;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
`ifdef SRAM_ARB_RR_EN
    logic              last_b;
    assign grant_b = B_Req && (!A_Req || !last_b);
    // remember which port won the latest grant so ties alternate
    always_ff @(posedge Clk or posedge Reset)
        if (Reset)
            last_b <= 1'b1;
        else if (state == IDLE && (A_Req || B_Req))
            last_b <= grant_b;
`else
    assign grant_b = B_Req && !A_Req;
`endif
    assign sel_we    = grant_b ? B_WE : A_WE;
    assign sel_addr  = grant_b ? B_Addr : A_Addr;
    assign sel_wdata = grant_b ? B_WData : A_WData;
    assign SRAM_DQ   = dq_oe ? wdata_q : 'z;
    // access sequencer: every SRAM pin and handshake output is registered here
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op_we     <= 1'b0;
            op_b      <= 1'b0;
            dq_oe     <= 1'b0;
            wdata_q   <= '0;
            Busy      <= 1'b0;
            A_Ack     <= 1'b0;
            B_Ack     <= 1'b0;
            A_RData   <= '0;
            B_RData   <= '0;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_ADDR <= '0;
        end else
            case (state)
                IDLE:
                    if (A_Req || B_Req) begin
                        state     <= SETUP;
                        Busy      <= 1'b1;
                        op_b      <= grant_b;
                        op_we     <= sel_we;
                        dq_oe     <= sel_we;
                        wdata_q   <= sel_wdata;
                        SRAM_ADDR <= sel_addr;
                        SRAM_CE_N <= 1'b0;
                        SRAM_LB_N <= 1'b0;
                        SRAM_UB_N <= 1'b0;
                        SRAM_OE_N <= sel_we;
                        SRAM_WE_N <= 1'b1;
                    end
                SETUP: begin
                    state     <= ACCESS;
                    cnt       <= CW'(ACCESS_CYCLES - 1);
                    SRAM_WE_N <= !op_we;
                end
                ACCESS:
                    if (cnt == '0) begin
                        state     <= DONE;
                        SRAM_WE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        A_Ack     <= !op_b;
                        B_Ack     <= op_b;
                        if (!op_we && !op_b)
                            A_RData <= SRAM_DQ;
                        if (!op_we && op_b)
                            B_RData <= SRAM_DQ;
                    end else
                        cnt <= cnt - 1'b1;
                DONE: begin
                    state     <= IDLE;
                    Busy      <= 1'b0;
                    A_Ack     <= 1'b0;
                    B_Ack     <= 1'b0;
                    dq_oe     <= 1'b0;
                    SRAM_CE_N <= 1'b1;
                    SRAM_LB_N <= 1'b1;
                    SRAM_UB_N <= 1'b1;
                end
                default: state <= IDLE;
            endcase
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: random two-port traffic checked against a transaction-timeline model of the arbiter
module tb_sram_arbiter;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int AC = 2;
`ifdef SRAM_ARB_RR_EN
    localparam int TIE_G1 = 1;
`else
    localparam int TIE_G1 = 0;
`endif
    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          A_Req = 1'b0, A_WE = 1'b0, B_Req = 1'b0, B_WE = 1'b0;
    logic [AW-1:0] A_Addr = '0, B_Addr = '0;
    logic [DW-1:0] A_WData = '0, B_WData = '0;
    logic [DW-1:0] A_RData, B_RData;
    logic          A_Ack, B_Ack, Busy;
    logic          SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N;
    logic [AW-1:0] SRAM_ADDR;
    tri1  [DW-1:0] SRAM_DQ;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)) dut (
        .Clk(Clk), .Reset(Reset),
        .A_Req(A_Req), .A_WE(A_WE), .A_Addr(A_Addr), .A_WData(A_WData), .A_RData(A_RData), .A_Ack(A_Ack),
        .B_Req(B_Req), .B_WE(B_WE), .B_Addr(B_Addr), .B_WData(B_WData), .B_RData(B_RData), .B_Ack(B_Ack),
        .Busy(Busy), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_LB_N(SRAM_LB_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ)
    );

    always #5 Clk = ~Clk;

    // async SRAM part: drives the bus on reads, stores on the rising edge of WE_N
    logic [DW-1:0] sram [256] = '{default: '0};
    assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? sram[SRAM_ADDR[7:0]] : 'z;
    always @(posedge SRAM_WE_N)
        if (!SRAM_CE_N && !Reset)
            sram[SRAM_ADDR[7:0]] <= SRAM_DQ;

    // reference model: m_k is the position inside the current access
    // (0 idle, 1 setup, 2..AC+1 access, AC+2 done)
    int            m_k;
    logic          m_port, m_we;
    logic [AW-1:0] m_addr, e_addr;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] e_rd [2];
    logic [DW-1:0] mmem [256] = '{default: '0};
`ifdef SRAM_ARB_RR_EN
    logic          m_last_b;
`endif
    int tests = 0, fails = 0, cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_k = 0; m_port = 0; m_we = 0; m_addr = '0; m_wd = '0;
        e_rd[0] = '0; e_rd[1] = '0; e_addr = '0;
`ifdef SRAM_ARB_RR_EN
        m_last_b = 1'b1;
`endif
    endtask

    task automatic model_step();
        if (m_k == 0) begin
            if (A_Req || B_Req) begin
`ifdef SRAM_ARB_RR_EN
                m_port   = (A_Req && B_Req) ? ~m_last_b : B_Req;
                m_last_b = m_port;
`else
                m_port = ~A_Req;
`endif
                m_we   = m_port ? B_WE : A_WE;
                m_addr = m_port ? B_Addr : A_Addr;
                m_wd   = m_port ? B_WData : A_WData;
                e_addr = m_addr;
                m_k    = 1;
            end
        end else if (m_k == AC + 2)
            m_k = 0;
        else begin
            if (m_k == AC + 1 && m_we)
                mmem[m_addr[7:0]] = m_wd;
            if (m_k == AC + 1 && !m_we)
                e_rd[m_port] = mmem[m_addr[7:0]];
            m_k++;
        end
    endtask

    task automatic compare();
        chk("busy", Busy, m_k != 0);
        chk("ce_n", SRAM_CE_N, m_k == 0);
        chk("lb_n", SRAM_LB_N, m_k == 0);
        chk("ub_n", SRAM_UB_N, m_k == 0);
        chk("oe_n", SRAM_OE_N, !(!m_we && m_k >= 1 && m_k <= AC + 1));
        chk("we_n", SRAM_WE_N, !(m_we && m_k >= 2 && m_k <= AC + 1));
        chk("sram_addr", SRAM_ADDR, e_addr);
        chk("a_ack", A_Ack, m_k == AC + 2 && !m_port);
        chk("b_ack", B_Ack, m_k == AC + 2 && m_port);
        chk("a_rdata", A_RData, e_rd[0]);
        chk("b_rdata", B_RData, e_rd[1]);
        if (m_k != 0 && m_we)
            chk("dq_write", SRAM_DQ, m_wd);
        else if (m_k == 0 || m_k == AC + 2)
            chk("dq_release", SRAM_DQ, 16'hFFFF);
        else
            chk("dq_read", SRAM_DQ, mmem[m_addr[7:0]]);
    endtask

    task automatic cycle();
        @(negedge Clk);
        cyc++;
        if (Reset)
            model_reset();
        else
            model_step();
        compare();
    endtask

    task automatic a_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        output int ack_t, output int we_lo, output int oe_lo, output int dq_hit,
                        output logic [AW-1:0] addr_done);
        A_Req = 1; A_WE = we; A_Addr = addr; A_WData = wd;
        ack_t = -1; we_lo = 0; oe_lo = 0; dq_hit = 0; addr_done = '0;
        for (int t = 1; t <= 12 && ack_t < 0; t++) begin
            cycle();
            if (!SRAM_WE_N) we_lo++;
            if (!SRAM_OE_N) oe_lo++;
            if (SRAM_DQ === wd) dq_hit++;
            if (t == 2) begin
                A_Addr = 20'h00055; A_WData = 16'h1234; A_WE = ~we;
            end
            if (A_Ack) begin
                ack_t = t; addr_done = SRAM_ADDR; A_Req = 0;
            end
        end
        A_Req = 0;
    endtask

    initial begin
        int ack_t, we_lo, oe_lo, dq_hit, n;
        int ord [3];
        logic [AW-1:0] ad;
        cycle();
        cycle();
        chk("rst_ce_n", SRAM_CE_N, 1);
        chk("rst_oe_n", SRAM_OE_N, 1);
        chk("rst_we_n", SRAM_WE_N, 1);
        chk("rst_lb_ub", {SRAM_LB_N, SRAM_UB_N}, 2'b11);
        chk("rst_dq", SRAM_DQ, 16'hFFFF);
        chk("rst_acks", {A_Ack, B_Ack}, 0);
        chk("rst_rdata", {A_RData, B_RData}, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_addr", SRAM_ADDR, 0);
        Reset = 0;
        cycle();
        // simultaneous requests held high through three accesses
        A_Req = 1; B_Req = 1; A_WE = 0; B_WE = 0; A_Addr = 20'h00020; B_Addr = 20'h00021;
        n = 0;
        ord[0] = -1; ord[1] = -1; ord[2] = -1;
        for (int t = 0; t < 40 && n < 3; t++) begin
            cycle();
            if (A_Ack) begin ord[n] = 0; n++; end
            else if (B_Ack) begin ord[n] = 1; n++; end
        end
        A_Req = 0; B_Req = 0;
        chk("tie_count", n, 3);
        chk("tie_g0", ord[0], 0);
        chk("tie_g1", ord[1], TIE_G1);
        chk("tie_g2", ord[2], 0);
        cycle();
        cycle();
        a_op(1, 20'h00010, 16'hBEEF, ack_t, we_lo, oe_lo, dq_hit, ad);
        chk("wr_ack_t", ack_t, 4);
        chk("wr_we_lo", we_lo, 2);
        chk("wr_oe_lo", oe_lo, 0);
        chk("wr_dq_hits", dq_hit, 4);
        chk("wr_addr_held", ad, 20'h00010);
        cycle();
        a_op(0, 20'h00010, 16'h0000, ack_t, we_lo, oe_lo, dq_hit, ad);
        chk("rd_ack_t", ack_t, 4);
        chk("rd_oe_lo", oe_lo, 3);
        chk("rd_we_lo", we_lo, 0);
        chk("rd_a_rdata", A_RData, 16'hBEEF);
        chk("rd_b_rdata", B_RData, 16'h0000);
        cycle();
        // reset in the middle of a write access, away from any clock edge
        B_Req = 1; B_WE = 1; B_Addr = 20'h00030; B_WData = 16'hA5A5;
        for (int t = 0; t < 10 && m_k != 2; t++)
            cycle();
        chk("pre_rst_we_n", SRAM_WE_N, 0);
        #2 Reset = 1;
        #1;
        chk("mid_rst_ce_n", SRAM_CE_N, 1);
        chk("mid_rst_we_n", SRAM_WE_N, 1);
        chk("mid_rst_dq", SRAM_DQ, 16'hFFFF);
        chk("mid_rst_busy", Busy, 0);
        chk("mid_rst_b_ack", B_Ack, 0);
        B_Req = 0;
        cycle();
        Reset = 0;
        cycle();
        chk("post_rst_busy", Busy, 0);
        chk("post_rst_b_ack", B_Ack, 0);
        // random traffic obeying the Req/Ack handshake
        for (int i = 0; i < 3000; i++) begin
            cycle();
            if (A_Req && A_Ack)
                A_Req = 0;
            else if (A_Req || $urandom_range(0, 2) == 0) begin
                if (A_Req && !(m_k != 0 && !m_port) && $urandom_range(0, 15) == 0)
                    A_Req = 0;
                else
                    A_Req = 1;
                A_WE = 1'($urandom_range(0, 1)); A_Addr = AW'($urandom_range(0, 255)); A_WData = DW'($urandom);
            end
            if (B_Req && B_Ack)
                B_Req = 0;
            else if (B_Req || $urandom_range(0, 2) == 0) begin
                if (B_Req && !(m_k != 0 && m_port) && $urandom_range(0, 15) == 0)
                    B_Req = 0;
                else
                    B_Req = 1;
                B_WE = 1'($urandom_range(0, 1)); B_Addr = AW'($urandom_range(0, 255)); B_WData = DW'($urandom);
            end
        end
        A_Req = 0; B_Req = 0;
        repeat (12) cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the board's single asynchronous SRAM between two requesters: port A (CPU memory controller) and port B (debug/program loader).
- Grants one access at a time and sequences the SRAM control pins through a fixed setup/access/done FSM.
- Owns the SRAM_DQ tristate and returns registered read data with a one-cycle Ack pulse.
- Sits between the CPU memory controller / loader and the top-level SRAM pins.

Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.
- ACCESS_CYCLES, 2, number of ACCESS-state cycles (≥1) that satisfy SRAM tAA/tWP at CLOCK_50.

Ports:
- Clk  in  1  system clock (CLOCK_50 domain).
- Reset  in  1  asynchronous, active-high reset.
- A_Req  in  1  port A request level.
- A_WE  in  1  port A op: 1=write, 0=read.
- A_Addr  in  ADDR_W  port A address.
- A_WData  in  DATA_W  port A write data.
- A_RData  out  DATA_W  port A registered read data.
- A_Ack  out  1  port A completion pulse.
- B_Req, B_WE, B_Addr, B_WData, B_RData, B_Ack: same as port A, for port B.
- Busy  out  1  high in any state other than IDLE.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N  out  1 each  SRAM strobes, active-low.
- SRAM_ADDR  out  ADDR_W  SRAM address (registered).
- SRAM_DQ  inout  DATA_W  SRAM data bus.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-access):
  - State goes to IDLE.
  - All SRAM_*_N = 1, SRAM_ADDR = 0, SRAM_DQ = Z.
  - A_Ack = B_Ack = 0, A_RData = B_RData = 0, Busy = 0.
  - RR pointer = "B last served".
- FSM states: IDLE -> SETUP -> ACCESS (ACCESS_CYCLES cycles, down-counter) -> DONE -> IDLE.
- IDLE:
  - Samples A_Req/B_Req. If either is high, latch the winner's Addr, WE and WData into internal registers, record the grant, go to SETUP.
  - Otherwise stay in IDLE.
- SETUP:
  - CE_N = 0, LB_N = UB_N = 0, SRAM_ADDR = latched address.
  - Read: OE_N = 0. Write: OE_N = 1 and DQ driven with latched data.
  - WE_N = 1.
- ACCESS:
  - Same strobes as SETUP, except WE_N = 0 for writes.
  - On the last ACCESS cycle of a read, SRAM_DQ is captured into the granted port's RData at the clock edge.
- DONE:
  - WE_N = 1, OE_N = 1. CE_N, LB_N, UB_N stay 0 and address/data are held (write hold time).
  - Granted port's Ack = 1 for exactly this one cycle.
- Latency: request sampled at edge N -> Ack high during cycle N+2+ACCESS_CYCLES (cycle count from N+1). Each access is 3+ACCESS_CYCLES cycles including the return to IDLE.
- Handshake:
  - Requester holds Req until it sees Ack, and must deassert Req on the edge at which Ack is sampled high.
  - Req still high in the following IDLE cycle is a new request.
  - Addr/WE/WData are only sampled in IDLE, so changes after grant are ignored.
- RData: updates only on reads for that port, and holds otherwise. The other port's RData and Ack are unaffected.
- SRAM_DQ is driven only when the current op is a write and the state is SETUP, ACCESS or DONE; it is Z otherwise.
- Simultaneous A_Req and B_Req: resolved by the arbitration policy (see Optional Feature).
- The losing requester waits with no timeout. Its Req stays pending and is served in the next IDLE cycle.
- A Req that drops before grant is simply not served. Nothing is latched.

Optional Feature:
- Macro SRAM_ARB_RR_EN.
- Defined: round-robin. On simultaneous requests, grant the port not served last. The pointer updates at each grant.
- Undefined: fixed priority, A always wins ties. No RR pointer is generated. Port B can starve while A requests back-to-back.

Test Plan:
- Reset=1 then release; hold idle -> all SRAM_*_N=1, DQ=Z, Acks=0, RData=0, Busy=0.
- A write Addr=20'h00010, WData=16'hBEEF, ACCESS_CYCLES=2 -> WE_N low exactly 2 cycles, DQ=BEEF during SETUP..DONE, A_Ack one pulse 4 cycles after request sampled.
- A read Addr=20'h00010 with SRAM model -> OE_N low 3 cycles, A_RData=16'hBEEF at A_Ack, B_RData stays 0.
- A_Req and B_Req rise same cycle, held through 3 transactions, with SRAM_ARB_RR_EN defined -> grant order A,B,A. Undefined (A held high) -> A,A,A and B unserved.
- Reset asserted during ACCESS of a write -> WE_N/CE_N go high and DQ goes Z in the same cycle with no clock edge, no Ack, FSM in IDLE after release.
- A_Addr and A_WData changed during ACCESS -> SRAM_ADDR and DQ keep the latched values until DONE ends.
